// File: rtl/i2c_cfg_master.sv
// Single-master I2C write engine: START, address+W, two payload bytes with ACK checks, STOP.
// SCL and SDA are open-drain enables; every bit is four phases of Q_DIV clk cycles.
module i2c_cfg_master #(
  parameter int Q_DIV = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int QW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] data_q, data_d;
  logic        ack_err_q, ack_err_d;
  logic        q_last;
  logic        seg_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    q_last    = (qcnt_q == QW'(Q_DIV - 1));
    seg_last  = q_last && (phase_q == 2'd3);

    // Quarter/phase counters run in every bus state; the phase wraps 3->0 on its own.
    if (state_q != S_IDLE && state_q != S_DONE) begin
      qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
      if (q_last) begin
        phase_d = phase_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d    = data;
          shift_d   = {dev_addr, 1'b0};
          ack_err_d = 1'b0;
          byte_d    = '0;
          bit_d     = '0;
          qcnt_d    = '0;
          phase_d   = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (seg_last) begin
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        if (seg_last) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_ACK;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      S_ACK: begin
        if (q_last && phase_q == 2'd2 && sda_in) begin
          ack_err_d = 1'b1;
        end
        // ack_err_q already holds this bit's sample by the end of phase 3.
        if (seg_last) begin
          if (ack_err_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            shift_d = (byte_q == 2'd0) ? data_q[15:8] : data_q[7:0];
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        if (seg_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        sda_oe = phase_q[1];
      end
      S_BIT: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = ~shift_q[7];
      end
      S_ACK: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
      end
      S_STOP: begin
        scl_oe = (phase_q == 2'd0);
        sda_oe = ~phase_q[1];
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign ack_err = ack_err_q;

endmodule

// File: doc/i2c_cfg_master.md
I2C_CFG_MASTER -- requirements
Module: i2c_cfg_master

Interface
REQ-001 SHALL have parameter Q_DIV, default 16, giving clk cycles per quarter SCL bit; SCL = 6.4 MHz / (4*16) = 100 kHz on the PLL 6.4 MHz output.
REQ-002 SHALL have port clk  input  1  single clock, driven by the PLL 6.4 MHz output (outclk_0).
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one write transaction; sampled only in IDLE.
REQ-005 SHALL have port dev_addr  input  7  7-bit slave address; captured when start is accepted.
REQ-006 SHALL have port data  input  16  payload, sent MSB byte first; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  transaction in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at end of transaction.
REQ-009 SHALL have port ack_err  output  1  a slave NACK occurred in the last transaction.
REQ-010 SHALL have port scl_oe  output  1  1 = drive SCL low; 0 = release (open-drain).
REQ-011 SHALL have port sda_oe  output  1  1 = drive SDA low; 0 = release (open-drain).
REQ-012 SHALL have port sda_in  input  1  SDA pad value, already synchronised.

Function
REQ-013 SHALL implement the states IDLE, START, BIT, ACK, STOP and DONE, driven by a quarter-bit counter that counts 0..Q_DIV-1 and a phase counter that counts 0..3.
REQ-014 SHALL accept start only in IDLE, capture dev_addr and data, clear ack_err and enter START on the next edge; start while busy SHALL be ignored.
REQ-015 SHALL drive busy=1 from the first cycle out of IDLE through the DONE cycle inclusive.
REQ-016 SHALL, in START, release SDA and SCL for phases 0-1, then drive SDA low with SCL released for phases 2-3.
REQ-017 SHALL, for each data bit in BIT: phase 0 drives SCL low and updates SDA to the bit value (sda_oe = ~bit); phases 1-2 release SCL; phase 3 drives SCL low.
REQ-018 SHALL shift out 3 bytes MSB-first: {dev_addr,1'b0}, data[15:8], data[7:0]; each byte SHALL be followed by one ACK bit.
REQ-019 SHALL, in ACK, use the BIT timing with SDA released and sample sda_in on the last cycle of phase 2; sda_in=1 SHALL mean NACK.
REQ-020 SHALL, on NACK, set ack_err=1, skip the remaining bytes and enter STOP after that ACK bit completes.
REQ-021 SHALL, in STOP: phase 0 drives SCL and SDA low; phase 1 releases SCL; phases 2-3 release SDA with SCL released.
REQ-022 SHALL, in DONE, pulse done=1 for exactly one cycle, then return to IDLE with busy=0 on the following cycle.
REQ-023 SHALL make the full ACKed transaction take 116*Q_DIV cycles from the first START cycle to the DONE cycle (1856 at the default), computed as 4Q START + 27 bits * 4Q + 4Q STOP.
REQ-024 SHALL hold ack_err stable from DONE until the next accepted start.
REQ-025 SHALL ignore start sampled in the DONE cycle; start is accepted from IDLE the following cycle.

Reset
REQ-026 SHALL, on any clk edge with reset_n=0, force IDLE with scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0 and all counters at 0.
REQ-027 SHALL release both lines on the first clk edge of a reset applied mid-transaction, with no STOP generated and the bus left as-is.

Verification
REQ-028 SHALL be tested with: dev_addr=0x1A, data=0x1234, slave ACKs every byte -> SDA bytes 0x34, 0x12, 0x34; done 1856 cycles after the first START cycle; ack_err=0.
REQ-029 SHALL be tested with: dev_addr=0x1A, slave NACKs the address byte -> ack_err=1; STOP follows the first ACK bit; done after 44*16=704 cycles.
REQ-030 SHALL be tested with: start pulsed at cycle 100 of a busy transaction with different dev_addr/data -> ignored; the original frame completes unaltered.
REQ-031 SHALL be tested with: reset_n=0 during bit 5 of the second byte -> the next edge gives scl_oe=0, sda_oe=0, busy=0; a new start then produces a full correct frame.
REQ-032 SHALL be tested with: start held high continuously -> done pulses and busy is 0 for exactly one cycle; the next frame starts the cycle after that IDLE cycle.
REQ-033 SHALL be tested with: Q_DIV=2, data=0xFFFF, slave ACKs -> total 232 cycles; SCL high time is 4 cycles per bit; no SDA edge occurs while SCL is released except during START and STOP.
